// File: rtl/cipher_pkg.sv
// cipher_pkg
// Definitions shared by the round sequencer, the datapath input mux and the
// key-schedule unit of the block-cipher core.
//   cipher_state_t : sequencer states (IDLE / KEY / DONE)
//   SEL_INIT       : datapath mux select, load input ^ round key (initial add)
//   SEL_ROUND      : datapath mux select, load round(state) ^ round key
//   NR_AES128      : default number of full rounds after the initial add
package cipher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        DONE = 2'd2
    } cipher_state_t;

    localparam logic SEL_INIT  = 1'b0;
    localparam logic SEL_ROUND = 1'b1;

    localparam int NR_AES128 = 10;

endpackage

// File: rtl/cipher_round_cnt.sv
// cipher_round_cnt
// Round index counter for the cipher sequencer. Clear wins over enable, and
// the count holds at NR so the index can never run past the last round key.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0
//   en         : advance by one (ignored once the count has reached NR)
//   rnd        : current round index, 0..NR
//   last       : rnd == NR
module cipher_round_cnt #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] rnd,
    output logic          last
);

    localparam logic [RW-1:0] NR_V = RW'(NR);

    logic [RW-1:0] rnd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q <= '0;
        end else if (clr) begin
            rnd_q <= '0;
        end else if (en && (rnd_q != NR_V)) begin
            rnd_q <= rnd_q + RW'(1);
        end
    end

    assign rnd  = rnd_q;
    assign last = (rnd_q == NR_V);

endmodule

// File: rtl/cipher_round_ctrl.sv
// cipher_round_ctrl
// Control sequencer for the iterative round datapath. For each accepted block
// it fetches round keys 0..NR from the key schedule and strobes the state
// register once per delivered key: key 0 with the initial AddRoundKey, keys
// 1..NR with the round function, the last one without MixColumns.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : block input handshake
//   abort                : synchronous cancel back to IDLE
//   rk_req / rk_idx      : round key request and index
//   rk_ack               : round key present on the datapath this cycle
//   st_en                : load the state register this cycle
//   dp_sel               : SEL_INIT for the initial add, SEL_ROUND afterwards
//   mc_bypass            : final round, skip MixColumns
//   out_valid / out_ready: result handshake
//   dbg_state            : current sequencer state (cipher_state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid (and its payload) stable until the transfer;
// ready may come and go freely. rk_req/rk_ack follow the same rule with rk_req
// as valid. abort overrides every transfer in the cycle it is asserted.
module cipher_round_ctrl
    import cipher_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic          rk_req,
    output logic [RW-1:0] rk_idx,
    input  logic          rk_ack,
    output logic          st_en,
    output logic          dp_sel,
    output logic          mc_bypass,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    dbg_state
);

    cipher_state_t state_q, state_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic [RW-1:0] rnd;
    logic          rnd_last;

    cipher_round_cnt #(
        .NR(NR),
        .RW(RW)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .rnd  (rnd),
        .last (rnd_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        st_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = KEY;
                    cnt_clr = 1'b1;
                end
            end
            KEY: begin
                // The key and the state load complete in the same cycle.
                if (rk_ack) begin
                    st_en = 1'b1;
                    if (rnd_last) begin
                        state_d = DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            DONE: begin
                // Index is cleared on handoff so IDLE always shows rnd = 0.
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
        // Cancel beats everything, including a pending result.
        if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
            st_en   = 1'b0;
        end
    end

    // Registered decodes only: no input reaches these outputs.
    assign in_ready  = (state_q == IDLE);
    assign rk_req    = (state_q == KEY);
    assign out_valid = (state_q == DONE);
    assign rk_idx    = rnd;
    assign dp_sel    = rk_req ? ((rnd != '0) ? SEL_ROUND : SEL_INIT) : 1'b0;
    assign mc_bypass = rk_req & rnd_last;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// tb_cipher_round_ctrl
// Directed bench for cipher_round_ctrl at NR=10. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, so each sample shows the state
// set up by the previous rising edge combined with this cycle's inputs.
module tb_cipher_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic          rk_ack = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          rk_req;
    logic [RW-1:0] rk_idx;
    logic          st_en;
    logic          dp_sel;
    logic          mc_bypass;
    logic          out_valid;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;

    cipher_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .rk_req(rk_req), .rk_idx(rk_idx), .rk_ack(rk_ack),
        .st_en(st_en), .dp_sel(dp_sel), .mc_bypass(mc_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not finish within bound");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- driver tasks ----------------
    // Present a block for one edge; after this the DUT sits in KEY at idx 0.
    task automatic accept_block();
        @(negedge clk);
        in_valid = 1'b1;
        rk_ack   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sit in DONE, hand the result off, leave the DUT in IDLE.
    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        rk_ack    = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        rk_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (rk_req !== 1'b0) begin failures++; $display("FAIL reset_rk_req: got %b want 0", rk_req); end
        checks++; if (st_en !== 1'b0) begin failures++; $display("FAIL reset_st_en: got %b want 0", st_en); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (rk_idx !== 4'd0) begin failures++; $display("FAIL reset_rnd: got %0d want 0", rk_idx); end
        @(negedge clk);
        rst_n  = 1'b1;
        rk_ack = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid = 1'b1;
        rk_ack   = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i <= NR; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++; if (st_en !== 1'b1) begin failures++; $display("FAIL single_st_en idx%0d: got %b want 1", i, st_en); end
            checks++; if (rk_idx !== 4'(i)) begin failures++; $display("FAIL single_rk_idx: got %0d want %0d", rk_idx, i); end
            checks++; if (dp_sel !== (i != 0)) begin failures++; $display("FAIL single_dp_sel idx%0d: got %b want %b", i, dp_sel, (i != 0)); end
            checks++; if (mc_bypass !== (i == NR)) begin failures++; $display("FAIL single_mc_bypass idx%0d: got %b want %b", i, mc_bypass, (i == NR)); end
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL single_busy idx%0d: out_valid=%b in_ready=%b want 0 0", i, out_valid, in_ready); end
        end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid: got %b want 1 at 12 cycles", out_valid); end
        checks++; if (st_en !== 1'b0 || rk_req !== 1'b0 || dp_sel !== 1'b0 || mc_bypass !== 1'b0) begin failures++; $display("FAIL single_done_quiet: st_en=%b rk_req=%b dp_sel=%b mc=%b want 0", st_en, rk_req, dp_sel, mc_bypass); end
        handoff();
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL single_after_handoff: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_stall();
        accept_block();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (st_en !== 1'b1 || rk_idx !== 4'(i)) begin failures++; $display("FAIL stall_pre idx%0d: st_en=%b rk_idx=%0d", i, st_en, rk_idx); end
            @(negedge clk);
        end
        rk_ack = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (rk_req !== 1'b1 || rk_idx !== 4'd5 || st_en !== 1'b0) begin failures++; $display("FAIL stall_hold s%0d: rk_req=%b rk_idx=%0d st_en=%b want 1 5 0", s, rk_req, rk_idx, st_en); end
            @(negedge clk);
        end
        rk_ack = 1'b1;
        for (int i = 5; i <= NR; i++) begin
            #1;
            checks++; if (st_en !== 1'b1 || rk_idx !== 4'(i) || out_valid !== 1'b0) begin failures++; $display("FAIL stall_post idx%0d: st_en=%b rk_idx=%0d out_valid=%b", i, st_en, rk_idx, out_valid); end
            @(negedge clk);
        end
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_done: out_valid=%b want 1 at 15 cycles", out_valid); end
        handoff();
    endtask

    task automatic test_backpressure();
        accept_block();
        repeat (NR + 1) @(negedge clk);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold k%0d: out_valid=%b in_ready=%b want 1 0", k, out_valid, in_ready); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_take: out_valid=%b want 1", out_valid); end
        @(negedge clk);
        out_ready = 1'b0;
        rk_ack    = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_abort();
        accept_block();
        repeat (7) @(negedge clk);
        abort = 1'b1;
        #1;
        checks++; if (rk_idx !== 4'd7 || rk_req !== 1'b1) begin failures++; $display("FAIL abort_idx: rk_idx=%0d rk_req=%b want 7 1", rk_idx, rk_req); end
        checks++; if (st_en !== 1'b0) begin failures++; $display("FAIL abort_st_en: got %b want 0", st_en); end
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || dbg_state !== 2'd0 || rk_idx !== 4'd0 || rk_req !== 1'b0) begin failures++; $display("FAIL abort_idle: in_ready=%b state=%0d rnd=%0d rk_req=%b want 1 0 0 0", in_ready, dbg_state, rk_idx, rk_req); end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (st_en !== 1'b1 || rk_idx !== 4'd0 || dp_sel !== 1'b0) begin failures++; $display("FAIL abort_restart: st_en=%b rk_idx=%0d dp_sel=%b want 1 0 0", st_en, rk_idx, dp_sel); end
        // Run this block to DONE, then cancel the pending result.
        repeat (NR + 1) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_reach_done: out_valid=%b want 1", out_valid); end
        abort = 1'b1;
        @(negedge clk);
        abort  = 1'b0;
        rk_ack = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL abort_drop: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_async_reset();
        accept_block();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || rk_req !== 1'b0 || in_ready !== 1'b1 || st_en !== 1'b0) begin failures++; $display("FAIL areset_outputs: out_valid=%b rk_req=%b in_ready=%b st_en=%b want 0 0 1 0", out_valid, rk_req, in_ready, st_en); end
        @(negedge clk);
        rst_n = 1'b1;
        accept_block();
        for (int i = 0; i <= NR; i++) begin
            #1;
            checks++; if (st_en !== 1'b1 || rk_idx !== 4'(i)) begin failures++; $display("FAIL areset_rerun idx%0d: st_en=%b rk_idx=%0d", i, st_en, rk_idx); end
            @(negedge clk);
        end
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_done: out_valid=%b want 1", out_valid); end
        handoff();
    endtask

    task automatic test_back_to_back();
        int acc1 = -1;
        int acc2 = -1;
        int ho1  = -1;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rk_ack    = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (in_valid && in_ready) begin
                if (acc1 < 0) acc1 = n;
                else if (acc2 < 0) acc2 = n;
            end
            if (out_valid && out_ready && ho1 < 0) ho1 = n;
            @(negedge clk);
        end
        checks++; if (acc2 < 0 || ho1 < 0) begin failures++; $display("FAIL b2b_seen: acc2=%0d ho1=%0d want both seen", acc2, ho1); end
        checks++; if (acc2 - ho1 !== 1) begin failures++; $display("FAIL b2b_gap: got %0d want 1", acc2 - ho1); end
        checks++; if (acc2 - acc1 !== NR + 3) begin failures++; $display("FAIL b2b_period: got %0d want %0d", acc2 - acc1, NR + 3); end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort  = 1'b0;
        rk_ack = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_stall();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cipher_round_ctrl.md
# cipher_round_ctrl

Iterative-cipher sequencer that drives the shared round datapath (AddRoundKey XOR, round function, 128-bit state register) of the block-cipher core. It accepts one block per transaction and steps the datapath through the initial key addition and NR rounds. Each step fetches round key `rnd` from the key-schedule unit over a req/ack handshake. It presents the finished block through a valid/ready output handshake. Datapath and key storage live outside this block; it produces only control.

## Interface
- `NR`, 10: number of full rounds after the initial AddRoundKey (1..15).
- `RW`, 4: round-index width; must satisfy 2^RW > NR.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  plaintext block present on datapath input.
- `in_ready`  out  1  controller idle; block accepted on `in_valid & in_ready`.
- `abort`  in  1  synchronous cancel; returns to IDLE next edge.
- `rk_req`  out  1  request round key `rk_idx`.
- `rk_idx`  out  RW  index of requested round key (0..NR).
- `rk_ack`  in  1  round key valid on datapath key input this cycle.
- `st_en`  out  1  load state register this cycle.
- `dp_sel`  out  1  0 = load input^key (initial add), 1 = load round(state)^key.
- `mc_bypass`  out  1  final round: skip MixColumns.
- `out_valid`  out  1  state register holds the result.
- `out_ready`  in  1  consumer takes result on `out_valid & out_ready`.

## Operation
- States: IDLE, KEY, DONE.
- IDLE: `in_ready`=1. On `in_valid`, go to KEY and clear `rnd`=0.
- KEY: `rk_req`=1, `rk_idx`=`rnd`. `rk_req` is held until `rk_ack`. On `rk_ack`: `st_en`=1 in that same cycle.
  - If `rnd`<NR, increment `rnd` and stay in KEY.
  - If `rnd`==NR, go to DONE.
- `rk_ack` is ignored outside KEY.
- `dp_sel` = (`rnd`!=0). `mc_bypass` = (`rnd`==NR). Both are decoded from registered `rnd`, and are valid whenever `rk_req`=1; otherwise 0.
- DONE: `out_valid`=1, held stable until `out_ready`. On `out_ready`, go to IDLE.
- No overlap: the next block is accepted no earlier than the cycle after the handoff.
- `abort` has priority over all transitions in any state.
  - Next state is IDLE and `rnd`=0.
  - `st_en` is forced 0 in the abort cycle.
  - An `out_valid` block is dropped.
- Reset (async, any time, mid-round included): state IDLE, `rnd`=0, `rk_req`=0, `st_en`=0, `out_valid`=0. `in_ready`=1 as soon as `rst_n` is low.
- `rnd` never exceeds NR. No wrap is possible.

## Timing
- `in_ready`, `rk_req`, `out_valid`, `rk_idx`, `dp_sel`, `mc_bypass` are pure decodes of registered state and `rnd` (glitch-free, no input-to-output path).
- `st_en` = KEY & `rk_ack` & !`abort`. This is the only combinational input-to-output path.
- With `rk_ack` tied 1 and acceptance at edge 0: KEY during cycles 1..NR+1, `st_en` high during cycles 1..NR+1, `out_valid` high from cycle NR+2. For NR=10, `out_valid` is high 12 cycles after acceptance.
- Each `rk_ack` stall cycle adds exactly one cycle of latency.
- Throughput with an always-ready consumer and ack: one block per NR+3 cycles.

## Structure
- Shared package `cipher_pkg`:
  - state enum (IDLE/KEY/DONE);
  - `dp_sel` encodings SEL_INIT=0, SEL_ROUND=1;
  - default NR_AES128=10.
- This package is also used by the datapath mux and the key-schedule unit.
- One sub-module, `cipher_round_cnt`: RW-bit counter with clear, enable, and terminal flag `rnd==NR`.
- The FSM and output decode live in the top.

## Test plan
- Reset release, `rk_ack`=1, one block at NR=10: `st_en` pulses 11 consecutive cycles with `rk_idx` 0..10. `dp_sel`=0 only at idx 0. `mc_bypass`=1 only at idx 10. `out_valid` rises 12 cycles after acceptance.
- `rk_ack` low for 3 cycles at idx 5: `rk_req` holds, `rk_idx`=5, `st_en`=0. Completion is delayed by exactly 3 cycles.
- `out_ready`=0 for 4 cycles after done: `out_valid` stays 1 and `in_ready`=0. After `out_ready`, `in_ready`=1 the next cycle.
- `abort` at idx 7: next cycle IDLE, `in_ready`=1, `rnd`=0. No `st_en` in the abort cycle. A new block restarts at idx 0.
- `rst_n` pulsed low asynchronously mid-KEY: outputs go immediately to reset values (`out_valid`=0, `rk_req`=0, `in_ready`=1). A fresh block then completes normally.
- Back-to-back blocks with `in_valid` held 1: a second acceptance occurs exactly one cycle after the first `out_valid & out_ready`. Period is 13 cycles at NR=10.
